// File: rtl/packet_arb_pkg.sv
// ----------------------------------------------------------------------------
// packet_arb_pkg
// Shared types and helpers for the packet arbiters.
//   arb_state_t : arbiter FSM states (ARB = choosing a source, XFER = moving
//                 packets from the granted source)
//   rr_pick     : rotate-priority search; returns the first index at or after
//                 ptr (cyclic over n entries) whose req bit is set. When no bit
//                 is set it returns ptr, so callers qualify it with |req.
// ----------------------------------------------------------------------------
package packet_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Widest request vector rr_pick can search; callers zero-extend into it.
   localparam int RR_MAX = 32;

   function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                  input int                ptr,
                                  input int                n);
      int j;
      rr_pick = ptr;
      // Walk from the farthest offset back to offset 0 so the nearest
      // requester after ptr is the one left in the result.
      for (int i = RR_MAX-1; i >= 0; i--) begin
         if (i < n) begin
            j = ptr + i;
            if (j >= n) begin
               j = j - n;
            end
            if (req[j[4:0]]) begin
               rr_pick = j;
            end
         end
      end
   endfunction

endpackage

// File: rtl/if_axi_stream.sv
// ----------------------------------------------------------------------------
// if_axi_stream
// Packet stream bundle with valid/ready handshake.
//   dat : DAT_BYTS*8 payload         val : beat valid
//   sop : first beat of a packet     eop : last beat of a packet
//   err : packet error flag          mod : valid bytes on the eop beat
//   ctl : CTL_BITS sideband          rdy : sink accepts the beat
// Modports: source drives everything but rdy; sink drives rdy only.
// ----------------------------------------------------------------------------
interface if_axi_stream #(
   parameter int DAT_BYTS = 8,
   parameter int CTL_BITS = 8
) ();
   localparam int DAT_BITS = DAT_BYTS*8;
   localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

   logic [DAT_BITS-1:0] dat;
   logic                val;
   logic                sop;
   logic                eop;
   logic                err;
   logic [MOD_BITS-1:0] mod;
   logic [CTL_BITS-1:0] ctl;
   logic                rdy;

   modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
   modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/rr_pick_comb.sv
// ----------------------------------------------------------------------------
// rr_pick_comb
// Masked rotate-priority encoder: finds the first set request at or after ptr,
// wrapping around NUM_IN entries.
//   req   : NUM_IN request bits
//   ptr   : search start index
//   idx   : chosen index (meaningful only when found=1)
//   found : at least one request is set
// ----------------------------------------------------------------------------
module rr_pick_comb
   import packet_arb_pkg::*;
#(
   parameter int NUM_IN      = 4,
   parameter int LOG2_NUM_IN = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0]      req,
   input  logic [LOG2_NUM_IN-1:0] ptr,
   output logic [LOG2_NUM_IN-1:0] idx,
   output logic                   found
);

   logic [RR_MAX-1:0] req_ext;
   int                pick;

   always_comb begin
      req_ext             = '0;
      req_ext[NUM_IN-1:0] = req;
      pick                = rr_pick(req_ext, int'(ptr), NUM_IN);
      idx                 = LOG2_NUM_IN'(pick);
      found               = |req;
   end

endmodule

// File: rtl/packet_arb_wrr.sv
// ----------------------------------------------------------------------------
// packet_arb_wrr
// Weighted round-robin packet arbiter. Merges NUM_IN packet streams onto one
// registered output; a grant lasts whole packets and each source may send up
// to its weight of consecutive packets per turn. The source index is written
// into ctl[OVR_WRT_BIT +: LOG2_NUM_IN] of every forwarded beat.
//   i_clk     : clock
//   i_rst     : synchronous reset, active low
//   i_weight  : weight of input k at [k*WGT_BITS +: WGT_BITS], 0 disables it
//   i_axi     : packet sources
//   o_axi     : merged output (one register stage)
//   o_pkt_cnt : per-input forwarded packet counters at [k*CNT_BITS +: CNT_BITS]
// Build option: define PACKET_ARB_WRR_STATS_EN to implement the packet
// counters; otherwise o_pkt_cnt is constant zero.
// ----------------------------------------------------------------------------
module packet_arb_wrr
   import packet_arb_pkg::*;
#(
   parameter int DAT_BYTS    = 8,
   parameter int DAT_BITS    = DAT_BYTS*8,
   parameter int CTL_BITS    = 8,
   parameter int NUM_IN      = 4,
   parameter int LOG2_NUM_IN = $clog2(NUM_IN),
   parameter int OVR_WRT_BIT = CTL_BITS - LOG2_NUM_IN,
   parameter int WGT_BITS    = 4,
   parameter int CNT_BITS    = 32
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [NUM_IN*WGT_BITS-1:0] i_weight,
   if_axi_stream.sink                 i_axi [NUM_IN-1:0],
   if_axi_stream.source               o_axi,
   output logic [NUM_IN*CNT_BITS-1:0] o_pkt_cnt
);

   localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

   // flattened view of the source bundles
   logic [NUM_IN-1:0]   in_val;
   logic [NUM_IN-1:0]   in_sop;
   logic [NUM_IN-1:0]   in_eop;
   logic [NUM_IN-1:0]   in_err;
   logic [DAT_BITS-1:0] in_dat [NUM_IN];
   logic [MOD_BITS-1:0] in_mod [NUM_IN];
   logic [CTL_BITS-1:0] in_ctl [NUM_IN];
   logic [WGT_BITS-1:0] wgt    [NUM_IN];
   logic [NUM_IN-1:0]   req;
   logic [NUM_IN-1:0]   rdy_vec;

   // arbiter state
   arb_state_t             state_reg,  state_next;
   logic [LOG2_NUM_IN-1:0] grant_reg,  grant_next;
   logic [LOG2_NUM_IN-1:0] rr_ptr_reg, rr_ptr_next;
   logic [WGT_BITS-1:0]    credit_reg, credit_next;
   logic                   gap_reg,    gap_next;   // between packets of one turn

   // output register
   logic                val_reg;
   logic                sop_reg;
   logic                eop_reg;
   logic                err_reg;
   logic [DAT_BITS-1:0] dat_reg;
   logic [MOD_BITS-1:0] mod_reg;
   logic [CTL_BITS-1:0] ctl_reg;

   logic                   out_free;
   logic                   g_val, g_sop, g_eop, g_err;
   logic [DAT_BITS-1:0]    g_dat;
   logic [MOD_BITS-1:0]    g_mod;
   logic [CTL_BITS-1:0]    g_ctl;
   logic [CTL_BITS-1:0]    ctl_stamp;
   logic                   xfer_rdy;
   logic                   accept;
   logic [LOG2_NUM_IN-1:0] ptr_inc;
   logic [LOG2_NUM_IN-1:0] pick_ptr;
   logic [LOG2_NUM_IN-1:0] pick_idx;
   logic                   pick_found;
   logic [WGT_BITS-1:0]    credit_dec;

   genvar gi;

   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_in
         assign in_val[gi]   = i_axi[gi].val;
         assign in_sop[gi]   = i_axi[gi].sop;
         assign in_eop[gi]   = i_axi[gi].eop;
         assign in_err[gi]   = i_axi[gi].err;
         assign in_dat[gi]   = i_axi[gi].dat;
         assign in_mod[gi]   = i_axi[gi].mod;
         assign in_ctl[gi]   = i_axi[gi].ctl;
         assign i_axi[gi].rdy = rdy_vec[gi];
         assign wgt[gi]      = i_weight[gi*WGT_BITS +: WGT_BITS];
         // only packet starts from enabled inputs may win arbitration
         assign req[gi]      = in_val[gi] & in_sop[gi] & (wgt[gi] != '0);
         assign rdy_vec[gi]  = xfer_rdy & (grant_reg == LOG2_NUM_IN'(gi));
      end
   endgenerate

   assign out_free = ~val_reg | o_axi.rdy;
   assign g_val    = in_val[grant_reg];
   assign g_sop    = in_sop[grant_reg];
   assign g_eop    = in_eop[grant_reg];
   assign g_err    = in_err[grant_reg];
   assign g_dat    = in_dat[grant_reg];
   assign g_mod    = in_mod[grant_reg];
   assign g_ctl    = in_ctl[grant_reg];

   // In the gap after an eop only a fresh sop may continue the turn, so a
   // stray mid-packet beat is never swallowed there.
   assign xfer_rdy = (state_reg == XFER) & out_free & ~(gap_reg & ~g_sop);
   assign accept   = xfer_rdy & g_val;

   assign ptr_inc    = (grant_reg == LOG2_NUM_IN'(NUM_IN-1)) ? '0
                                                              : grant_reg + LOG2_NUM_IN'(1);
   // The gap cycle doubles as the arbitration cycle when the turn ends there.
   assign pick_ptr   = (state_reg == ARB) ? rr_ptr_reg : ptr_inc;
   assign credit_dec = credit_reg - WGT_BITS'(1);

   rr_pick_comb #(
      .NUM_IN      (NUM_IN),
      .LOG2_NUM_IN (LOG2_NUM_IN)
   ) u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      rr_ptr_next = rr_ptr_reg;
      credit_next = credit_reg;
      gap_next    = gap_reg;
      case (state_reg)
         ARB: begin
            if (pick_found) begin
               state_next  = XFER;
               grant_next  = pick_idx;
               credit_next = wgt[pick_idx];
               gap_next    = 1'b0;
            end
         end
         XFER: begin
            if (gap_reg && !(g_val && g_sop)) begin
               // granted input has no next packet ready: its turn ends now
               rr_ptr_next = ptr_inc;
               gap_next    = 1'b0;
               if (pick_found) begin
                  grant_next  = pick_idx;
                  credit_next = wgt[pick_idx];
               end else begin
                  state_next = ARB;
               end
            end else if (accept) begin
               gap_next = 1'b0;
               if (g_eop) begin
                  credit_next = credit_dec;
                  // a weight dropped to zero ends the turn at this packet
                  if ((credit_dec != '0) && (wgt[grant_reg] != '0)) begin
                     gap_next = 1'b1;
                  end else begin
                     state_next  = ARB;
                     rr_ptr_next = ptr_inc;
                  end
               end
            end
         end
         default: state_next = ARB;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_reg  <= ARB;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
         credit_reg <= '0;
         gap_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
         credit_reg <= credit_next;
         gap_reg    <= gap_next;
      end
   end

   always_comb begin
      ctl_stamp                                = g_ctl;
      ctl_stamp[OVR_WRT_BIT +: LOG2_NUM_IN]    = grant_reg;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         val_reg <= 1'b0;
         sop_reg <= 1'b0;
         eop_reg <= 1'b0;
         err_reg <= 1'b0;
         dat_reg <= '0;
         mod_reg <= '0;
         ctl_reg <= '0;
      end else if (accept) begin
         val_reg <= 1'b1;
         sop_reg <= g_sop;
         eop_reg <= g_eop;
         err_reg <= g_err;
         dat_reg <= g_dat;
         mod_reg <= g_mod;
         ctl_reg <= ctl_stamp;
      end else if (o_axi.rdy) begin
         val_reg <= 1'b0;
      end
   end

   assign o_axi.val = val_reg;
   assign o_axi.sop = sop_reg;
   assign o_axi.eop = eop_reg;
   assign o_axi.err = err_reg;
   assign o_axi.dat = dat_reg;
   assign o_axi.mod = mod_reg;
   assign o_axi.ctl = ctl_reg;

`ifdef PACKET_ARB_WRR_STATS_EN
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_cnt
         logic [CNT_BITS-1:0] cnt_reg;
         always_ff @(posedge i_clk) begin
            if (!i_rst) begin
               cnt_reg <= '0;
            end else if (accept && g_eop && (grant_reg == LOG2_NUM_IN'(gi))) begin
               cnt_reg <= cnt_reg + CNT_BITS'(1);
            end
         end
         assign o_pkt_cnt[gi*CNT_BITS +: CNT_BITS] = cnt_reg;
      end
   endgenerate
`else
   assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_packet_arb_wrr.sv
// ----------------------------------------------------------------------------
// tb_packet_arb_wrr
// Directed bench for packet_arb_wrr (NUM_IN=4, 8-byte beats, 8-bit ctl).
// Each source replays a preloaded list of beats; forwarded beats are captured
// with the cycle they appeared and compared with hand-worked expectations.
// Beat data layout: [63:56] source, [15:8] packet number, [7:0] beat number.
// ----------------------------------------------------------------------------
module tb_packet_arb_wrr;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  weight;
   logic         o_rdy;
   logic [3:0]   s_val, s_sop, s_eop, s_err;
   wire  [3:0]   s_rdy;
   logic [63:0]  s_dat [4];
   logic [2:0]   s_mod [4];
   logic [7:0]   s_ctl [4];
   wire  [127:0] pkt_cnt;

   always #5 clk = ~clk;

   if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) in_if [3:0] ();
   if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(8)) out_if ();

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_src
         assign in_if[gi].val = s_val[gi];
         assign in_if[gi].sop = s_sop[gi];
         assign in_if[gi].eop = s_eop[gi];
         assign in_if[gi].err = s_err[gi];
         assign in_if[gi].dat = s_dat[gi];
         assign in_if[gi].mod = s_mod[gi];
         assign in_if[gi].ctl = s_ctl[gi];
         assign s_rdy[gi]     = in_if[gi].rdy;
      end
   endgenerate
   assign out_if.rdy = o_rdy;

   packet_arb_wrr dut (
      .i_clk     (clk),
      .i_rst     (rst_n),
      .i_weight  (weight),
      .i_axi     (in_if),
      .o_axi     (out_if),
      .o_pkt_cnt (pkt_cnt)
   );

   // source beat lists
   logic [63:0] q_dat [4][64];
   logic        q_sop [4][64];
   logic        q_eop [4][64];
   int          q_len [4];
   int          q_head [4];
   int          acc_cnt [4];

   // captured output beats
   logic [63:0] cap_dat [64];
   logic [7:0]  cap_ctl [64];
   logic        cap_sop [64];
   logic        cap_eop [64];
   int          cap_src [64];
   int          cap_cyc [64];
   int          ncap;
   int          cyc;

   int checks = 0;
   int errors = 0;

   int e1_src [12] = '{0, 1, 1, 2, 0, 1, 1, 2, 0, 1, 1, 2};
   int e1_pk  [12] = '{0, 0, 1, 0, 1, 2, 3, 1, 2, 4, 5, 2};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic push_pkt(input int k, input int len, input int pk);
      for (int b = 0; b < len; b++) begin
         q_dat[k][q_len[k]] = {8'(k), 40'd0, 8'(pk), 8'(b)};
         q_sop[k][q_len[k]] = (b == 0);
         q_eop[k][q_len[k]] = (b == len-1);
         q_len[k]++;
      end
   endtask

   task automatic present();
      for (int k = 0; k < 4; k++) begin
         if (q_head[k] < q_len[k]) begin
            s_val[k] = 1'b1;
            s_sop[k] = q_sop[k][q_head[k]];
            s_eop[k] = q_eop[k][q_head[k]];
            s_dat[k] = q_dat[k][q_head[k]];
         end else begin
            s_val[k] = 1'b0;
            s_sop[k] = 1'b0;
            s_eop[k] = 1'b0;
            s_dat[k] = '0;
         end
         s_err[k] = 1'b0;
         s_mod[k] = 3'd7;
         s_ctl[k] = 8'hD5;
      end
   endtask

   task automatic clear_srcs();
      for (int k = 0; k < 4; k++) begin
         q_len[k]   = 0;
         q_head[k]  = 0;
         acc_cnt[k] = 0;
      end
   endtask

   // One clock: handshakes are sampled at the falling edge and take effect
   // at the following rising edge; stimulus is updated just after that edge.
   task automatic tick();
      logic [3:0]  acc;
      logic        fire;
      logic [63:0] fd;
      logic [7:0]  fc;
      logic        fs, fe;
      @(negedge clk);
      acc  = s_val & s_rdy;
      fire = out_if.val & o_rdy;
      fd   = out_if.dat;
      fc   = out_if.ctl;
      fs   = out_if.sop;
      fe   = out_if.eop;
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 4; k++) begin
         if (acc[k]) begin
            q_head[k]++;
            acc_cnt[k]++;
         end
      end
      if (fire && ncap < 64) begin
         cap_dat[ncap] = fd;
         cap_ctl[ncap] = fc;
         cap_sop[ncap] = fs;
         cap_eop[ncap] = fe;
         cap_src[ncap] = int'(fc[7:6]);
         cap_cyc[ncap] = cyc;
         $display("beat %0d cyc %0d src %0d dat %h sop %0b eop %0b",
                  ncap, cyc, fc[7:6], fd, fs, fe);
         ncap++;
      end
      present();
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int b = 0;
      while (ncap < n && b < budget) begin
         tick();
         b++;
      end
      chk({tag, "_timeout"}, 64'(ncap >= n), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_srcs();
      present();
      repeat (3) tick();
      rst_n = 1'b1;
      ncap  = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic changed;
      int   b;
      cyc    = 0;
      ncap   = 0;
      o_rdy  = 1'b1;
      weight = 16'h0121;
      clear_srcs();
      present();

      // ---------------- reset state ----------------
      do_reset();
      chk("rst_val", 64'(out_if.val), 64'd0);
      chk("rst_sop", 64'(out_if.sop), 64'd0);
      chk("rst_eop", 64'(out_if.eop), 64'd0);
      chk("rst_err", 64'(out_if.err), 64'd0);
      chk("rst_dat", out_if.dat, 64'd0);
      chk("rst_mod", 64'(out_if.mod), 64'd0);
      chk("rst_ctl", 64'(out_if.ctl), 64'd0);
      chk("rst_rdy", 64'(s_rdy), 64'd0);
      chk("rst_cnt_lo", pkt_cnt[63:0], 64'd0);
      chk("rst_cnt_hi", pkt_cnt[127:64], 64'd0);

      // ---------------- weights 1,2,1,0 with 1-beat packets ----------------
      $display("test weighted order");
      weight = 16'h0121;
      for (int k = 0; k < 4; k++)
         for (int p = 0; p < 8; p++) push_pkt(k, 1, p);
      present();
      run_until(12, 100, "t1");
      for (int i = 0; i < 12; i++) begin
         chk("t1_src", 64'(cap_src[i]), 64'(e1_src[i]));
         chk("t1_dat", cap_dat[i], {8'(e1_src[i]), 40'd0, 8'(e1_pk[i]), 8'd0});
      end
      chk("t1_gap_in_turn", 64'(cap_cyc[2] - cap_cyc[1]), 64'd1);
      chk("t1_gap_turn", 64'(cap_cyc[3] - cap_cyc[2]), 64'd2);

      // ---------------- 5-beat packet under toggling back-pressure ----------
      $display("test backpressure");
      do_reset();
      push_pkt(2, 5, 0);
      present();
      b = 0;
      while (ncap < 5 && b < 60) begin
         o_rdy = ~o_rdy;
         tick();
         b++;
      end
      chk("t2_timeout", 64'(ncap >= 5), 64'd1);
      o_rdy = 1'b1;
      repeat (10) tick();
      chk("t2_count", 64'(ncap), 64'd5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_dat", cap_dat[i], {8'd2, 40'd0, 8'd0, 8'(i)});
         chk("t2_ctl", 64'(cap_ctl[i]), 64'h95);
         chk("t2_sop", 64'(cap_sop[i]), 64'(i == 0));
         chk("t2_eop", 64'(cap_eop[i]), 64'(i == 4));
      end

      // ---------------- unused credit: one idle cycle, then next input ------
      $display("test early turn end");
      do_reset();
      weight = 16'h0131;
      push_pkt(1, 1, 0);
      push_pkt(2, 1, 0);
      present();
      run_until(2, 40, "t3");
      repeat (5) tick();
      chk("t3_count", 64'(ncap), 64'd2);
      chk("t3_src0", 64'(cap_src[0]), 64'd1);
      chk("t3_src1", 64'(cap_src[1]), 64'd2);
      chk("t3_gap", 64'(cap_cyc[1] - cap_cyc[0]), 64'd2);

      // ---------------- weight dropped to 0 mid-packet ----------------
      $display("test weight drop");
      do_reset();
      weight = 16'h0121;
      push_pkt(1, 3, 0);
      push_pkt(1, 3, 1);
      push_pkt(2, 1, 0);
      present();
      changed = 1'b0;
      b = 0;
      while (ncap < 4 && b < 60) begin
         tick();
         if (!changed && acc_cnt[1] == 1) begin
            weight  = 16'h0101;
            changed = 1'b1;
         end
         b++;
      end
      chk("t4_timeout", 64'(ncap >= 4), 64'd1);
      repeat (10) tick();
      chk("t4_count", 64'(ncap), 64'd4);
      chk("t4_src0", 64'(cap_src[0]), 64'd1);
      chk("t4_src2", 64'(cap_src[2]), 64'd1);
      chk("t4_eop2", 64'(cap_eop[2]), 64'd1);
      chk("t4_src3", 64'(cap_src[3]), 64'd2);

      // ---------------- reset in the middle of a packet ----------------
      $display("test mid-packet reset");
      do_reset();
      weight = 16'h1111;
      push_pkt(2, 1, 0);
      present();
      run_until(1, 40, "t5a");
      push_pkt(1, 6, 0);
      present();
      b = 0;
      while (acc_cnt[1] < 3 && b < 40) begin
         tick();
         b++;
      end
      chk("t5_beat3_timeout", 64'(acc_cnt[1] >= 3), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("t5_rst_val", 64'(out_if.val), 64'd0);
      chk("t5_rst_rdy", 64'(s_rdy), 64'd0);
      chk("t5_beats", 64'(ncap), 64'd4);
      chk("t5_no_eop", 64'(cap_eop[3]), 64'd0);
      clear_srcs();
      push_pkt(1, 1, 1);
      push_pkt(3, 1, 0);
      present();
      repeat (2) tick();
      rst_n = 1'b1;
      ncap  = 0;
      run_until(2, 40, "t5b");
      chk("t5_first_src", 64'(cap_src[0]), 64'd1);
      chk("t5_second_src", 64'(cap_src[1]), 64'd3);

      // ---------------- packet counters ----------------
      $display("test packet counters");
      do_reset();
      weight = 16'h0303;
      for (int p = 0; p < 7; p++) push_pkt(0, 2, p);
      for (int p = 0; p < 3; p++) push_pkt(2, 2, p);
      present();
      run_until(20, 200, "t6");
      repeat (3) tick();
`ifdef PACKET_ARB_WRR_STATS_EN
      chk("t6_cnt0", 64'(pkt_cnt[31:0]), 64'd7);
      chk("t6_cnt1", 64'(pkt_cnt[63:32]), 64'd0);
      chk("t6_cnt2", 64'(pkt_cnt[95:64]), 64'd3);
      chk("t6_cnt3", 64'(pkt_cnt[127:96]), 64'd0);
`else
      chk("t6_cnt0", 64'(pkt_cnt[31:0]), 64'd0);
      chk("t6_cnt1", 64'(pkt_cnt[63:32]), 64'd0);
      chk("t6_cnt2", 64'(pkt_cnt[95:64]), 64'd0);
      chk("t6_cnt3", 64'(pkt_cnt[127:96]), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
